// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD 7-segment scanner:
// converter FSM states and the digit-to-segment pattern table.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } dd_state_t;

    // All segments off. Used for non-decimal nibbles and blanked digits.
    localparam logic [6:0] BLANK = 7'b0000000;

    // Segment patterns {g,f,e,d,c,b,a}. The entry index is the nibble value.
    // The list runs from entry 15 down to entry 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        BLANK, BLANK, BLANK, BLANK, BLANK, BLANK,   // 15..10
        7'b1101111,                                 // 9
        7'b1111111,                                 // 8
        7'b0000111,                                 // 7
        7'b1111101,                                 // 6
        7'b1101101,                                 // 5
        7'b1100110,                                 // 4
        7'b1001111,                                 // 3
        7'b1011011,                                 // 2
        7'b0000110,                                 // 1
        7'b0111111                                  // 0
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Bus between the BCD scanner and its driver: the conversion request,
// status and result, and the multiplexed display outputs.
interface bcd_seg_scanner_if;
    logic [7:0]  value_i;
    logic        load_i;
    logic        busy_o;
    logic        valid_o;
    logic [11:0] bcd_o;
    logic [6:0]  seg_o;
    logic [2:0]  dig_o;

    modport master (
        output value_i, load_i,
        input  busy_o, valid_o, bcd_o, seg_o, dig_o
    );

    modport slave (
        input  value_i, load_i,
        output busy_o, valid_o, bcd_o, seg_o, dig_o
    );
endinterface

// File: rtl/bcd_seg_scanner_bin2bcd_dd.sv
// Sequential double-dabble: 8-bit binary to three BCD digits,
// one add-3/shift step per clock, eight steps per conversion.
module bin2bcd_dd
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value_i,
    input  logic        load_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [11:0] bcd_o
);

    dd_state_t   state_q, state_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] bcd_q, bcd_d;

    logic [11:0] adj;
    logic [19:0] shifted;

    // Add 3 to each scratch nibble of 5 or more, so it carries correctly on the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                              ? scratch_q[gi*4 +: 4] + 4'd3
                              : scratch_q[gi*4 +: 4];
    end

    assign shifted = {adj[10:0], bin_q, 1'b0};

    // Next-state and datapath: load in IDLE, shift in CONV, publish on the eighth shift.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    bin_d     = value_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shifted[19:8];
                bin_d     = shifted[7:0];
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = shifted[19:8];
                    state_d = DONE;
                end
            end
            DONE: begin
                // Requests arriving here are dropped, not queued.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy_o  = (state_q == CONV);
    assign valid_o = (state_q == DONE);
    assign bcd_o   = bcd_q;

endmodule

// File: rtl/bcd_seg_scanner.sv
// Binary-to-BCD display stage: converts a sampled 8-bit value and scans
// its three digits onto a shared 7-segment bus, SCAN_DIV cycles per digit.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// in the hundreds and tens positions.
module bcd_seg_scanner
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_seg_scanner_if.slave  bus
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [11:0]      bcd;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       dig_q, dig_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nibble;
    logic             blank;

    bin2bcd_dd u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_i (bus.value_i),
        .load_i  (bus.load_i),
        .busy_o  (bus.busy_o),
        .valid_o (bus.valid_o),
        .bcd_o   (bcd)
    );

    // Divider, digit index and the segment/enable pair for the next cycle.
    // seg and dig come from the same index so they switch on the same edge.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        case (idx_d)
            2'd0:    nibble = bcd[3:0];
            2'd1:    nibble = bcd[7:4];
            default: nibble = bcd[11:8];
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        blank = ((idx_d == 2'd2) && (bcd[11:8] == 4'd0)) ||
                ((idx_d == 2'd1) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0));
`else
        blank = 1'b0;
`endif

        dig_d = 3'b001 << idx_d;
        seg_d = blank ? BLANK : seg_decode(nibble);
    end

    // Scanner registers run continuously, independent of the converter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
            dig_q <= 3'b001;
            seg_q <= 7'b0111111;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            dig_q <= dig_d;
            seg_q <= seg_d;
        end
    end

    assign bus.bcd_o = bcd;
    assign bus.dig_o = dig_q;
    assign bus.seg_o = seg_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Scoreboard bench for bcd_seg_scanner with SCAN_DIV = 4.
module tb_bcd_seg_scanner;

    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_seg_scanner_if bus ();

    bcd_seg_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid_o pulse pops one expected result.
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got bcd_o=%03h, expected no pulse", bus.bcd_o);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                $display("conversion done: bcd_o=%03h expected=%03h", bus.bcd_o, e);
                check("bcd_result", {20'd0, bus.bcd_o}, {20'd0, e});
            end
        end
    end

    // One conversion: accept, count busy cycles, optionally inject a dropped
    // load (drop_at) or a reset (rst_at) on the given busy cycle.
    task automatic run_conv(input logic [7:0] v, input logic [11:0] exp,
                            input int drop_at, input int rst_at);
        int busy_cnt;
        bus.value_i = v;
        bus.load_i  = 1'b1;
        tick();
        bus.load_i  = 1'b0;
        if (rst_at == 0) begin
            exp_q.push_back(exp);
            exp_pulses++;
        end
        check("busy_after_accept", {31'd0, bus.busy_o}, 32'd1);
        busy_cnt = 0;
        while (bus.busy_o === 1'b1 && busy_cnt < 20) begin
            busy_cnt++;
            if (busy_cnt == drop_at) begin
                bus.value_i = 8'h07;
                bus.load_i  = 1'b1;
            end
            if (busy_cnt == rst_at) begin
                rst_n = 1'b0;
                tick();
                check("rst_bcd",   {20'd0, bus.bcd_o}, 32'h000);
                check("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
                check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
                check("rst_dig",   {29'd0, bus.dig_o}, 32'b001);
                check("rst_seg",   {25'd0, bus.seg_o}, 32'b0111111);
                $display("conversion of %02h aborted by reset", v);
                rst_n = 1'b1;
                return;
            end
            tick();
            bus.load_i = 1'b0;
        end
        check("busy_cycles", busy_cnt, 32'd8);
        check("valid_at_k8", {31'd0, bus.valid_o}, 32'd1);
        tick();
        check("valid_single", {31'd0, bus.valid_o}, 32'd0);
    endtask

    // Align to the first cycle of the ones digit, then check one full frame
    // plus the first cycle of the next.
    task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
        logic [2:0] prev;
        logic       found;
        logic [6:0] exp_seg;
        int         idx;
        found = 1'b0;
        prev  = bus.dig_o;
        for (int c = 0; c < 4 * SCAN_DIV && !found; c++) begin
            tick();
            if (prev == 3'b100 && bus.dig_o == 3'b001) found = 1'b1;
            prev = bus.dig_o;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL scan_sync: got no 100->001 transition, expected one within %0d cycles", 4 * SCAN_DIV);
            return;
        end
        for (int j = 0; j <= 3 * SCAN_DIV; j++) begin
            idx     = (j / SCAN_DIV) % 3;
            exp_seg = (idx == 0) ? s0 : (idx == 1) ? s1 : s2;
            check("scan_dig", {29'd0, bus.dig_o}, 32'(3'b001 << idx));
            check("scan_seg", {25'd0, bus.seg_o}, {25'd0, exp_seg});
            if (j != 3 * SCAN_DIV) tick();
        end
        $display("scan frame checked: bcd_o=%03h", bus.bcd_o);
    endtask

    logic [6:0] lead_zero_seg;

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero_seg = 7'b0000000;
`else
        lead_zero_seg = 7'b0111111;
`endif
        bus.value_i = 8'h00;
        bus.load_i  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bcd",   {20'd0, bus.bcd_o}, 32'h000);
        check("reset_valid", {31'd0, bus.valid_o}, 32'd0);
        check("reset_busy",  {31'd0, bus.busy_o}, 32'd0);
        check("reset_dig",   {29'd0, bus.dig_o}, 32'b001);
        check("reset_seg",   {25'd0, bus.seg_o}, 32'b0111111);
        $display("reset checked");
        rst_n = 1'b1;
        tick();

        run_conv(8'hFF, 12'h255, 0, 0);
        check_scan(7'b1101101, 7'b1101101, 7'b1011011);

        run_conv(8'h2A, 12'h042, 3, 0);
        tick();

        run_conv(8'h07, 12'h007, 0, 0);
        check_scan(7'b0000111, lead_zero_seg, lead_zero_seg);

        run_conv(8'hFF, 12'h000, 0, 4);
        repeat (12) tick();
        check("post_reset_bcd", {20'd0, bus.bcd_o}, 32'h000);

        run_conv(8'h64, 12'h100, 0, 0);
        repeat (4) tick();

        check("queue_empty", exp_q.size(), 32'd0);
        check("pulse_count", pulses, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
